// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: splits bus beats into instructions, queues them in a
// DEPTH-entry ring and hands one instruction plus its PC per cycle to decode.
// Optional build macro FETCH_BUF_STATS_EN adds stall/drop statistics counters.
module fetch_buffer #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned INSN_WIDTH     = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [ADDR_WIDTH-1:0]     flush_pc,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_DATA_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSN_WIDTH-1:0]     out_insn,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [$clog2(DEPTH):0]    count
`ifdef FETCH_BUF_STATS_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               drop_insns
`endif
);

  localparam int unsigned LANES      = BUS_DATA_WIDTH / INSN_WIDTH;
  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned SKIP_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned INSN_BYTES = INSN_WIDTH / 8;
  localparam int unsigned LANE_LSB   = $clog2(INSN_BYTES);

  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [SKIP_W-1:0]     skip;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      free_slots;
  logic [CNT_W-1:0]      push_n;
  logic [CNT_W-1:0]      pop_n;
  logic                  push;
  logic                  pop;

  // Handshakes and occupancy deltas, all derived from registered state
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count;
    in_ready   = (free_slots >= CNT_W'(LANES)) && !flush;
    out_valid  = (count != '0);
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    push_n     = push ? (CNT_W'(LANES) - CNT_W'(skip)) : '0;
    pop_n      = CNT_W'(pop);
    out_insn   = out_valid ? mem[rd_ptr] : '0;
    out_pc     = pc;
  end

  // Pointers, occupancy, head PC and restart lane offset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= '0;
      skip   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= flush_pc;
      skip   <= SKIP_W'(flush_pc >> LANE_LSB);
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        pc     <= pc + ADDR_WIDTH'(INSN_BYTES);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(push_n);
        skip   <= '0;
      end
      count <= count + push_n - pop_n;
    end
  end

  // Slot storage: lanes at or above skip land in consecutive slots from wr_ptr
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (l >= int'(skip)) begin
          mem[PTR_W'(wr_ptr + PTR_W'(l) - PTR_W'(skip))] <= in_data[l*INSN_WIDTH +: INSN_WIDTH];
        end
      end
    end
  end

`ifdef FETCH_BUF_STATS_EN
  logic [32:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_insns} + 33'(count);
  end

  // Saturating count of cycles where decode waited on an empty buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (out_ready && !out_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Saturating count of instructions discarded by redirects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_insns <= '0;
    end else if (flush) begin
      drop_insns <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule
